// File: rtl/bpsk_pkg.sv
// bpsk_pkg: shared width default, FSM state type and sample limits for the BPSK modulator.
package bpsk_pkg;
  localparam int DATA_W_DEF = 10;
  localparam logic signed [DATA_W_DEF-1:0] SAMPLE_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam logic signed [DATA_W_DEF-1:0] SAMPLE_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};
  typedef enum logic {IDLE, SYMBOL} state_t;
endpackage

// File: rtl/bpsk_sat_neg.sv
// bpsk_sat_neg: conditional two's complement negate that clips the most negative input to the maximum.
module bpsk_sat_neg #(
  parameter int DATA_W = 10
) (
  input  logic                     neg_i,
  input  logic signed [DATA_W-1:0] x_i,
  output logic signed [DATA_W-1:0] y_o
);
  localparam logic signed [DATA_W-1:0] MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MAX = {1'b0, {(DATA_W-1){1'b1}}};
  always_comb y_o = !neg_i ? x_i : (x_i == MIN) ? MAX : -x_i;
endmodule

// File: rtl/bpsk_mod.sv
// bpsk_mod: BPSK modulator holding each payload bit for SPS carrier ticks and negating the carrier for bit 1.
// Optional differential encoding of the payload when BPSK_DIFF_ENC_EN is defined.
module bpsk_mod
  import bpsk_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SPS    = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clken,
  input  logic signed [DATA_W-1:0] carrier_i,
  input  logic                     carrier_valid_i,
  input  logic                     bit_i,
  input  logic                     bit_valid_i,
  output logic                     bit_ready_o,
  output logic signed [DATA_W-1:0] mod_o,
  output logic                     mod_valid_o,
  output logic                     busy_o,
  output logic                     underrun_o,
  input  logic                     underrun_clr_i
);
  localparam int CNT_W = $clog2(SPS);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sym_q, sym_d, mv_q, mv_d, und_q, und_d, new_sym;
  logic signed [DATA_W-1:0] mod_q, mod_d, neg_out;
  logic tick, at_end, accept;
  assign tick        = clken & carrier_valid_i;
  assign at_end      = (state_q == SYMBOL) & tick & (cnt_q == CNT_W'(SPS-1));
  assign bit_ready_o = (state_q == IDLE) | at_end;
  assign accept      = bit_valid_i & bit_ready_o & clken;
`ifdef BPSK_DIFF_ENC_EN
  logic prev_q;
  assign new_sym = bit_i ^ prev_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) prev_q <= 1'b0;
    else if (accept) prev_q <= new_sym;
`else
  assign new_sym = bit_i;
`endif
  bpsk_sat_neg #(.DATA_W(DATA_W)) u_neg (.neg_i(sym_q), .x_i(carrier_i), .y_o(neg_out));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    mod_d   = mod_q;
    mv_d    = 1'b0;
    und_d   = und_q & ~underrun_clr_i;
    if (state_q == IDLE) begin
      if (accept) begin
        sym_d   = new_sym;
        cnt_d   = '0;
        state_d = SYMBOL;
      end
    end else if (tick) begin
      mod_d = neg_out;
      mv_d  = 1'b1;
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
      if (at_end && bit_valid_i) sym_d = new_sym;
      if (at_end && !bit_valid_i) begin
        state_d = IDLE;
        und_d   = 1'b1;
      end
    end
  end
  // Freezing mv_q with clken defers a masked strobe until the enable returns, so no sample is lost.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sym_q   <= 1'b0;
      mod_q   <= '0;
      mv_q    <= 1'b0;
      und_q   <= 1'b0;
    end else if (clken) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      mod_q   <= mod_d;
      mv_q    <= mv_d;
      und_q   <= und_d;
    end
  assign mod_o       = mod_q;
  assign mod_valid_o = mv_q & clken;
  assign busy_o      = (state_q == SYMBOL);
  assign underrun_o  = und_q;
endmodule

// File: tb/tb_bpsk_mod.sv
// tb_bpsk_mod: table-driven and scoreboarded checks of bpsk_mod with SPS=4.
module tb_bpsk_mod;
  localparam int SPS = 4;
  logic clk = 1'b0, reset_n = 1'b0, clken = 1'b1;
  logic signed [9:0] carrier_i = '0;
  logic carrier_valid_i = 1'b0, bit_i = 1'b0, bit_valid_i = 1'b0, underrun_clr_i = 1'b0;
  logic bit_ready_o, mod_valid_o, busy_o, underrun_o;
  logic signed [9:0] mod_o;
  int n_chk = 0, n_err = 0;
  logic sb_on = 1'b0, prev_tb = 1'b0;
  int exp_q[$];

  bpsk_mod #(.DATA_W(10), .SPS(SPS)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .carrier_i(carrier_i),
    .carrier_valid_i(carrier_valid_i), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
    .bit_ready_o(bit_ready_o), .mod_o(mod_o), .mod_valid_o(mod_valid_o),
    .busy_o(busy_o), .underrun_o(underrun_o), .underrun_clr_i(underrun_clr_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic enc(input logic s);
    logic b;
`ifdef BPSK_DIFF_ENC_EN
    b = s ^ prev_tb;
    prev_tb = s;
`else
    b = s;
`endif
    return b;
  endfunction

  function automatic int exp_val(input logic s, input int c);
    return !s ? c : (c == -512) ? 511 : -c;
  endfunction

  always @(negedge clk)
    if (sb_on && reset_n) begin
      if (!clken) chk("valid_while_clken_low", int'(mod_valid_o), 0);
      if (mod_valid_o) begin
        if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
        else chk("mod_o", int'(mod_o), exp_q.pop_front());
      end
    end

  task automatic burst(input logic [7:0] s, input int n, input int c0, input bit ramp,
                       input int per, input int gap_at);
    int k = 0, t = 0, cyc = 0, c = c0;
    logic cur, tick;
    sb_on = 1'b1;
    clken = 1'b1;
    underrun_clr_i = 1'b1;
    @(posedge clk); #1;
    underrun_clr_i = 1'b0;
    chk("underrun_cleared", int'(underrun_o), 0);
    bit_i = enc(s[0]);
    bit_valid_i = 1'b1;
    carrier_valid_i = 1'b0;
    #1 chk("ready_idle", int'(bit_ready_o), 1);
    @(posedge clk); #1;
    bit_valid_i = 1'b0;
    cur = s[0];
    chk("busy_after_accept", int'(busy_o), 1);
    while (k < n && cyc < 1000) begin
      clken = !(gap_at >= 0 && cyc >= gap_at && cyc < gap_at + 5);
      carrier_valid_i = (cyc % per == 0);
      carrier_i = 10'(c);
      bit_valid_i = 1'b0;
      tick = clken && carrier_valid_i;
      if (tick && t == SPS-1 && k+1 < n) begin
        bit_i = enc(s[k+1]);
        bit_valid_i = 1'b1;
      end
      #1 chk("ready_boundary", int'(bit_ready_o), int'(tick && t == SPS-1));
      chk("underrun_mid", int'(underrun_o), 0);
      if (tick) begin
        exp_q.push_back(exp_val(cur, c));
        if (ramp) c++;
        t++;
        if (t == SPS) begin
          t = 0;
          k++;
          if (k < n) cur = s[k];
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    if (k < n) chk("burst_timeout", k, n);
    clken = 1'b1;
    carrier_valid_i = 1'b0;
    bit_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("busy_end", int'(busy_o), 0);
    chk("underrun_end", int'(underrun_o), 1);
  endtask

  typedef struct { logic s; int c; int e; } vec_t;
  vec_t vt[8];

  initial begin
    vt[0] = '{1'b0,  100,  100};
    vt[1] = '{1'b1,  100, -100};
    vt[2] = '{1'b1, -512,  511};
    vt[3] = '{1'b1,  511, -511};
    vt[4] = '{1'b0, -512, -512};
    vt[5] = '{1'b0,  511,  511};
    vt[6] = '{1'b1,    0,    0};
    vt[7] = '{1'b1,   -1,    1};
    #12;
    chk("rst_mod_o", int'(mod_o), 0);
    chk("rst_valid", int'(mod_valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_underrun", int'(underrun_o), 0);
    chk("rst_ready", int'(bit_ready_o), 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (exp_val(vt[i].s, vt[i].c) != vt[i].e) chk("table_entry", exp_val(vt[i].s, vt[i].c), vt[i].e);
      sb_on = 1'b1;
      bit_i = enc(vt[i].s);
      bit_valid_i = 1'b1;
      carrier_valid_i = 1'b0;
      @(posedge clk); #1;
      bit_valid_i = 1'b0;
      carrier_valid_i = 1'b1;
      carrier_i = 10'(vt[i].c);
      repeat (SPS) begin
        exp_q.push_back(vt[i].e);
        @(posedge clk); #1;
      end
      carrier_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("vec_drained", exp_q.size(), 0);
      chk("vec_underrun", int'(underrun_o), 1);
      chk("vec_busy", int'(busy_o), 0);
    end
    burst(8'b0000_0101, 3, 1, 1'b1, 1, -1);
    burst(8'b0000_0010, 2, 20, 1'b1, 3, 4);
    reset_n = 1'b0;
    prev_tb = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
`ifdef BPSK_DIFF_ENC_EN
    burst(8'b0000_1001, 4, 30, 1'b0, 1, -1);
`else
    burst(8'b0000_1011, 4, 30, 1'b0, 1, -1);
`endif
    sb_on = 1'b0;
    bit_i = enc(1'b1);
    bit_valid_i = 1'b1;
    carrier_valid_i = 1'b1;
    carrier_i = 10'sd50;
    @(posedge clk); #1;
    bit_valid_i = 1'b0;
    chk("accept_tick_dropped", int'(mod_valid_o), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_mod_o", int'(mod_o), -50);
    reset_n = 1'b0;
    prev_tb = 1'b0;
    #1;
    chk("async_rst_mod_o", int'(mod_o), 0);
    chk("async_rst_valid", int'(mod_valid_o), 0);
    chk("async_rst_busy", int'(busy_o), 0);
    chk("async_rst_underrun", int'(underrun_o), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    carrier_valid_i = 1'b0;
    chk("post_rst_underrun", int'(underrun_o), 0);
    chk("post_rst_ready", int'(bit_ready_o), 1);
    burst(8'b0000_0000, 1, 7, 1'b0, 1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bpsk_mod.md
Name: bpsk_mod

Overview:
BPSK modulator stage, directly downstream of the NCO. Consumes the NCO's signed 10-bit sine carrier and its out_valid strobe, plus a serial payload bit stream via valid/ready handshake. Each bit is held for SPS carrier samples, and the carrier is passed (bit 0) or negated (bit 1). Output is a registered signed baseband-to-DAC sample stream with a valid strobe.

Parameters:
DATA_W, 10, carrier/output sample width (two's complement); matches NCO fsin_o width
SPS, 16, carrier samples per symbol; legal range 2..65535
CNT_W, $clog2(SPS), width of the sample-in-symbol counter (localparam, derived)

Ports:
clk  in  1  system clock, shared with NCO
reset_n  in  1  asynchronous active-low reset
clken  in  1  clock enable, same signal driving the NCO; all state frozen when low
carrier_i  in  DATA_W  signed carrier sample (NCO fsin_o)
carrier_valid_i  in  1  carrier sample valid (NCO out_valid)
bit_i  in  1  payload bit
bit_valid_i  in  1  payload bit valid
bit_ready_o  out  1  bit accepted when bit_valid_i & bit_ready_o & clken
mod_o  out  DATA_W  signed modulated sample
mod_valid_o  out  1  mod_o valid, one-cycle strobe per sample
busy_o  out  1  high while in SYMBOL state
underrun_o  out  1  sticky: stream ended mid-burst (no bit at symbol boundary)
underrun_clr_i  in  1  synchronous clear of underrun_o

Behaviour:
- tick = clken & carrier_valid_i. All registers update only when clken=1.
- Reset (async, reset_n=0): state=IDLE, cnt=0, sym=0, mod_o=0, mod_valid_o=0, busy_o=0, underrun_o=0, prev_sym=0.
- FSM states: IDLE, SYMBOL.
- IDLE: bit_ready_o=1. On accept: sym<=bit_i (mapped), cnt<=0, go to SYMBOL. No output is produced in IDLE, and carrier ticks are discarded.
- SYMBOL: on each tick, mod_o<= (sym ? -carrier_i : carrier_i), mod_valid_o<=1, cnt<=cnt+1. Without a tick, mod_valid_o<=0 and cnt holds.
- Symbol boundary: tick with cnt==SPS-1. bit_ready_o=1 combinationally only in that cycle (bit_ready_o = IDLE | (SYMBOL & tick & cnt==SPS-1)).
  - If bit_valid_i=1: load the new sym, cnt<=0, stay in SYMBOL. Back-to-back symbols are gapless.
  - Else: go to IDLE, cnt<=0, underrun_o<=1.
- The first symbol sample is the first tick after the accept cycle. A tick coinciding with the IDLE accept is not used.
- Latency: carrier_i on tick cycle N appears at mod_o on N+1, and mod_valid_o is high in N+1.
- Negation saturates: carrier_i = -2^(DATA_W-1) (-512) with sym=1 gives +2^(DATA_W-1)-1 (+511). No other clipping.
- mod_o holds its last value when mod_valid_o=0. It returns to 0 only on reset.
- underrun_o: set on SYMBOL->IDLE fall-through; underrun_clr_i clears it. If set and clear occur in the same cycle, set wins.
- busy_o = (state==SYMBOL), registered with the state.
- clken=0 mid-symbol: freeze everything, including cnt and sym. mod_valid_o is forced to 0 in those cycles.
- Reset mid-symbol: immediate return to IDLE. The partially sent symbol is lost and underrun_o is not set.

Optional Feature:
BPSK_DIFF_ENC_EN. When defined: differential encoding, sym = bit_i ^ prev_sym at each accept, and prev_sym<=sym. prev_sym persists across IDLE and is cleared only by reset. When undefined: sym = bit_i and no prev_sym register exists.

Decomposition:
- Shared package bpsk_pkg: DATA_W default, state enum (IDLE, SYMBOL), SAMPLE_MAX/SAMPLE_MIN constants.
- One natural sub-module: bpsk_sat_neg, a combinational conditional negate with saturation (DATA_W param) that the TX gain stage can reuse. FSM and counter stay in bpsk_mod.

Test Plan:
- SPS=4, carrier constant +100 valid every cycle, send bit 0 then stream ends -> four mod_o=+100 strobes one cycle after ticks, then IDLE; busy_o low and underrun_o=1.
- SPS=4, bits 1,0,1 back-to-back, carrier ramp 1,2,3,... -> mod_o = -1..-4, +5..+8, -9..-12 with no gap; bit_ready_o high exactly at cnt==3 ticks; underrun_o set only after the third symbol.
- carrier_i=-512 with bit 1 -> mod_o=+511; carrier_i=+511 with bit 1 -> mod_o=-511.
- carrier_valid_i every 3rd cycle plus clken low for 5 cycles mid-symbol -> cnt frozen, exactly SPS strobes per symbol, mod_valid_o never high while clken=0.
- Assert reset_n mid-symbol at cnt=2 -> all outputs 0 asynchronously; after release, next bit starts a fresh symbol with cnt=0 and underrun_o=0.
- With BPSK_DIFF_ENC_EN, bits 1,1,0,1 -> output signs -,+,+,- (sym 1,0,0,1). Without the macro -> -,-,+,-.
